// File: rtl/pipe_pkg.sv
// Shared constants for the front-end pipeline registers.
// Control bundle layout and the NOP encoding.
package pipe_pkg;
  localparam int CTRL_W = 9;

  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_ALUC_HI  = 4;
  localparam int CTRL_ALUC_LO  = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_REGDST   = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/pipe_reg_enc.sv
// Generic pipeline register: reset, enable (hold), clear, load.
// Priority is rst > hold > clr > load.
module pipe_reg_enc #(
  parameter int         W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // next-state: hold when disabled, zero on clear, else load
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      if (clr_i) q_d = '0;
      else       q_d = d_i;
    end
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) q_q <= RST_VAL;
    else     q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers driven by hazard stall/flush.
// Also keeps saturating stall and flush event counters.
module pipe_front_regs
  import pipe_pkg::*;
#(
  parameter int          DW       = 32,
  parameter logic [DW-1:0] RESET_PC = '0,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              flushE,
  input  logic [DW-1:0]     pcNextF,
  input  logic [DW-1:0]     instrF,
  input  logic [DW-1:0]     pcPlus4F,
  output logic [DW-1:0]     pcF,
  output logic [DW-1:0]     instrD,
  output logic [DW-1:0]     pcPlus4D,
  output logic              validD,
  input  logic [CTRL_W-1:0] ctrlD,
  input  logic [DW-1:0]     rd1D,
  input  logic [DW-1:0]     rd2D,
  input  logic [4:0]        rsD,
  input  logic [4:0]        rtD,
  input  logic [4:0]        rdD,
  input  logic [DW-1:0]     signImmD,
  output logic [CTRL_W-1:0] ctrlE,
  output logic [DW-1:0]     rd1E,
  output logic [DW-1:0]     rd2E,
  output logic [4:0]        rsE,
  output logic [4:0]        rtE,
  output logic [4:0]        rdE,
  output logic [DW-1:0]     signImmE,
  output logic              validE,
  output logic [CNT_W-1:0]  stallCnt,
  output logic [CNT_W-1:0]  flushCnt
);
  localparam int DWD = 2 * DW + 1;
  localparam int EWD = CTRL_W + 3 * DW + 16;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic [DWD-1:0] ifid_d, ifid_q;
  logic [EWD-1:0] idex_d, idex_q;

  pipe_reg_enc #(.W(DW), .RST_VAL(RESET_PC)) u_pc (
    .clk   (clk),
    .rst   (rst),
    .en_i  (~stallF),
    .clr_i (1'b0),
    .d_i   (pcNextF),
    .q_o   (pcF)
  );

  assign ifid_d = {1'b1, instrF, pcPlus4F};

  pipe_reg_enc #(.W(DWD)) u_ifid (
    .clk   (clk),
    .rst   (rst),
    .en_i  (~stallD),
    .clr_i (flushD),
    .d_i   (ifid_d),
    .q_o   (ifid_q)
  );

  assign {validD, instrD, pcPlus4D} = ifid_q;

  assign idex_d = {validD, ctrlD, rd1D, rd2D,
                   rsD, rtD, rdD, signImmD};

  pipe_reg_enc #(.W(EWD)) u_idex (
    .clk   (clk),
    .rst   (rst),
    .en_i  (1'b1),
    .clr_i (flushE),
    .d_i   (idex_d),
    .q_o   (idex_q)
  );

  assign {validE, ctrlE, rd1E, rd2E,
          rsE, rtE, rdE, signImmE} = idex_q;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // saturating increments for stall and flush events
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stallF && stall_cnt_q != CMAX)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((flushD || flushE) && flush_cnt_q != CMAX)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: directed scenarios plus random
// traffic compared against a behavioural model each cycle.
module tb_pipe_front_regs;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAXI = 15;

  logic clk = 0;
  logic rst, stallF, stallD, flushD, flushE;
  logic [DW-1:0] pcNextF, instrF, pcPlus4F;
  logic [DW-1:0] pcF, instrD, pcPlus4D;
  logic validD, validE;
  logic [8:0] ctrlD, ctrlE;
  logic [DW-1:0] rd1D, rd2D, signImmD;
  logic [DW-1:0] rd1E, rd2E, signImmE;
  logic [4:0] rsD, rtD, rdD, rsE, rtE, rdE;
  logic [CW-1:0] stallCnt, flushCnt;

  int tests = 0;
  int fails = 0;

  pipe_front_regs #(
    .DW(DW), .RESET_PC(32'h0), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE),
    .pcNextF(pcNextF), .instrF(instrF),
    .pcPlus4F(pcPlus4F), .pcF(pcF),
    .instrD(instrD), .pcPlus4D(pcPlus4D),
    .validD(validD), .ctrlD(ctrlD),
    .rd1D(rd1D), .rd2D(rd2D),
    .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .signImmD(signImmD), .ctrlE(ctrlE),
    .rd1E(rd1E), .rd2E(rd2E),
    .rsE(rsE), .rtE(rtE), .rdE(rdE),
    .signImmE(signImmE), .validE(validE),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  always #5 clk = ~clk;

  // behavioural model state
  logic [31:0] m_pc, m_iD, m_p4D;
  logic m_vD, m_vE;
  logic [8:0] m_cE;
  logic [31:0] m_r1E, m_r2E, m_imE;
  logic [4:0] m_rsE, m_rtE, m_rdE;
  int m_sc, m_fc;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_pc = 0; m_iD = 0; m_p4D = 0; m_vD = 0;
      m_vE = 0; m_cE = 0; m_r1E = 0; m_r2E = 0;
      m_imE = 0; m_rsE = 0; m_rtE = 0; m_rdE = 0;
      m_sc = 0; m_fc = 0;
    end else begin
      if (flushE) begin
        m_vE = 0; m_cE = 0; m_r1E = 0; m_r2E = 0;
        m_imE = 0; m_rsE = 0; m_rtE = 0; m_rdE = 0;
      end else begin
        m_vE = m_vD; m_cE = ctrlD;
        m_r1E = rd1D; m_r2E = rd2D; m_imE = signImmD;
        m_rsE = rsD; m_rtE = rtD; m_rdE = rdD;
      end
      if (!stallD) begin
        if (flushD) begin
          m_iD = 0; m_p4D = 0; m_vD = 0;
        end else begin
          m_iD = instrF; m_p4D = pcPlus4F; m_vD = 1;
        end
      end
      if (!stallF) m_pc = pcNextF;
      if (stallF) m_sc = (m_sc < CMAXI) ? m_sc + 1 : m_sc;
      if (flushD || flushE)
        m_fc = (m_fc < CMAXI) ? m_fc + 1 : m_fc;
    end
  endtask

  task automatic check_all();
    chk("pcF", pcF, m_pc);
    chk("instrD", instrD, m_iD);
    chk("pcPlus4D", pcPlus4D, m_p4D);
    chk("validD", validD, m_vD);
    chk("ctrlE", ctrlE, m_cE);
    chk("rd1E", rd1E, m_r1E);
    chk("rd2E", rd2E, m_r2E);
    chk("rsE", rsE, m_rsE);
    chk("rtE", rtE, m_rtE);
    chk("rdE", rdE, m_rdE);
    chk("signImmE", signImmE, m_imE);
    chk("validE", validE, m_vE);
    chk("stallCnt", stallCnt, m_sc[CW-1:0]);
    chk("flushCnt", flushCnt, m_fc[CW-1:0]);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rnd_data();
    pcNextF  = $urandom;
    instrF   = $urandom;
    pcPlus4F = $urandom;
    ctrlD    = 9'($urandom);
    rd1D     = $urandom;
    rd2D     = $urandom;
    signImmD = $urandom;
    rsD      = 5'($urandom);
    rtD      = 5'($urandom);
    rdD      = 5'($urandom);
  endtask

  task automatic ctl(input logic sf, input logic sd,
                     input logic fd, input logic fe);
    stallF = sf; stallD = sd; flushD = fd; flushE = fe;
  endtask

  logic [31:0] a, b, c, hold_pc, hold_i;
  logic [8:0] ca;

  initial begin
    rst = 1;
    ctl(0, 0, 0, 0);
    rnd_data();
    pcNextF = 32'h40;
    @(negedge clk);

    // reset held two cycles
    cyc();
    cyc();
    chk("rst_pc", pcF, 32'h0);
    chk("rst_vD", validD, 1'b0);
    chk("rst_vE", validE, 1'b0);
    chk("rst_sc", stallCnt, 4'h0);
    chk("rst_fc", flushCnt, 4'h0);

    rst = 0;
    pcNextF = 32'h40;
    cyc();
    chk("rel_pc", pcF, 32'h40);

    // streaming A, B, C
    a = $urandom; b = $urandom; c = $urandom;
    rnd_data(); instrF = a;
    cyc();
    chk("strm_A_D", instrD, a);
    chk("strm_A_vD", validD, 1'b1);
    rnd_data(); instrF = b;
    ca = ctrlD | 9'h100;
    ctrlD = ca;
    cyc();
    chk("strm_B_D", instrD, b);
    chk("strm_A_cE", ctrlE, ca);
    chk("strm_A_vE", validE, 1'b1);
    rnd_data(); instrF = c;
    cyc();
    chk("strm_C_D", instrD, c);

    // load-use stall
    hold_pc = pcF; hold_i = instrD;
    rnd_data();
    ctl(1, 1, 0, 1);
    cyc();
    chk("lu_pc", pcF, hold_pc);
    chk("lu_iD", instrD, hold_i);
    chk("lu_cE", ctrlE, 9'h0);
    chk("lu_vE", validE, 1'b0);
    chk("lu_sc", stallCnt, 4'h1);
    chk("lu_fc", flushCnt, 4'h1);

    // jump: flush D only
    rnd_data();
    ctl(0, 0, 1, 0);
    cyc();
    chk("jmp_iD", instrD, 32'h0);
    chk("jmp_vD", validD, 1'b0);
    chk("jmp_vE", validE, 1'b1);
    chk("jmp_r1E", rd1E, rd1D);

    // priority: stallD beats flushD
    rnd_data();
    ctl(0, 0, 0, 0);
    cyc();
    hold_i = instrD;
    rnd_data();
    ctl(1, 1, 1, 0);
    cyc();
    chk("pri_vD", validD, 1'b1);
    chk("pri_iD", instrD, hold_i);
    rnd_data();
    cyc();

    // reset in the middle of a stall
    rst = 1;
    rnd_data();
    cyc();
    chk("mrst_pc", pcF, 32'h0);
    chk("mrst_vD", validD, 1'b0);
    chk("mrst_iD", instrD, 32'h0);
    chk("mrst_sc", stallCnt, 4'h0);
    chk("mrst_fc", flushCnt, 4'h0);
    rst = 0;

    // saturation: 20 stall cycles
    ctl(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      rnd_data();
      cyc();
      if (i == 14) chk("sat15", stallCnt, 4'hF);
    end
    chk("sat20", stallCnt, 4'hF);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rnd_data();
      rst = ($urandom_range(0, 39) == 0);
      ctl(1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 4) == 0));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
